csd_term_issuer: RTL and testbench

- Upstream operand stage for the two-term shift-add multiplier (c = a<<b_i ± a<<b_j, or a<<b_i alone).
- Accepts a multiplicand a and a multiplier b. Recodes b into canonical signed digits (CSD, digits in {-1,0,+1}, no two adjacent non-zero).
- Issues the non-zero digits MSB-first, two per beat, as (b_i, b_j, b_sign, one_term) with a held copy of a.
- Side-band flags (pair_neg, term_zero, last) tell the downstream accumulator how to combine each beat.

---
 rtl/csd_pkg.sv | 41 ++++
 rtl/csd_recode.sv | 41 ++++
 rtl/csd_term_issuer.sv | 175 +++++++++++++++++
 tb/tb_csd_term_issuer.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/csd_pkg.sv
// Shared definitions for the CSD term issuer.
// Contents:
//   - default widths: A_W_DEF is the multiplicand width, N_DEF the shift width,
//     B_W_DEF the multiplier width and M_W the number of CSD digit positions
//   - the issuer state enum
//   - find_msb, a priority encoder that returns the highest set index and a
//     found flag
package csd_pkg;

    localparam int A_W_DEF = 16;
    localparam int N_DEF   = 4;
    localparam int M_W     = 32'd1 << N_DEF;
    localparam int B_W_DEF = M_W - 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    typedef struct packed {
        logic             found;
        logic [N_DEF-1:0] idx;
    } msb_t;

    // Highest set bit of v. idx is 0 when nothing is set.
    function automatic msb_t find_msb(input logic [M_W-1:0] v);
        msb_t r;
        r.found = 1'b0;
        r.idx   = '0;
        for (int i = 0; i < M_W; i++) begin
            if (v[i]) begin
                r.found = 1'b1;
                r.idx   = i[N_DEF-1:0];
            end else begin
                r.found = r.found;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/csd_recode.sv
// Combinational CSD (non-adjacent form) recoder.
// Ports:
//   b_in     : unsigned multiplier, B_W_DEF bits
//   pos_mask : positions that hold a +1 digit
//   neg_mask : positions that hold a -1 digit
// Recoding rule: digit i is non-zero exactly when b[i] ^ carry[i].
//   - The digit is -1 when b[i+1] is set and +1 otherwise.
//   - The next carry is the majority of b[i], b[i+1] and carry[i].
// Because the top bit of b is always 0, the final carry is 0, so 16 digit
// positions are enough to represent any input.
module csd_recode
    import csd_pkg::*;
(
    input  logic [B_W_DEF-1:0] b_in,
    output logic [M_W-1:0]     pos_mask,
    output logic [M_W-1:0]     neg_mask
);

    logic [M_W:0] b_ext_s;

    // Zero-extend b so that b[i+1] exists for every digit position
    always_comb begin
        b_ext_s = {2'b00, b_in};
    end

    // Carry-chain NAF recoding, LSB first
    always_comb begin : recode_blk
        logic carry_v;
        carry_v  = 1'b0;
        pos_mask = '0;
        neg_mask = '0;
        for (int i = 0; i < M_W; i++) begin
            pos_mask[i] = (b_ext_s[i] ^ carry_v) & ~b_ext_s[i+1];
            neg_mask[i] = (b_ext_s[i] ^ carry_v) &  b_ext_s[i+1];
            carry_v     = (b_ext_s[i] & b_ext_s[i+1]) |
                          (b_ext_s[i] & carry_v) |
                          (b_ext_s[i+1] & carry_v);
        end
    end

endmodule

// File: rtl/csd_term_issuer.sv
// CSD term issuer: operand stage for the two-term shift-add multiplier.
// The block accepts (a_in, b_in), recodes b into CSD digits and issues the
// non-zero digits MSB-first, two per beat.
// Input ports:
//   clk, rst_n      : clock and asynchronous active-low reset
//   in_vld, in_rdy  : operand handshake (a_in, b_in)
//   out_rdy         : downstream accepts the beat
// Beat outputs, qualified by vld:
//   a         : held multiplicand
//   b_i       : shift of the higher digit
//   b_j       : shift of the lower digit
//   one_term  : the beat carries a single digit
//   b_sign    : the two digits differ in sign, so the second term is subtracted
//   pair_neg  : the higher digit is -1, so the accumulator subtracts the beat
//   term_zero : b was 0 and the accumulator adds nothing
//   last      : final beat of the current operand
module csd_term_issuer
    import csd_pkg::*;
#(
    parameter int A_W = A_W_DEF,
    parameter int N   = N_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_vld,
    output logic           in_rdy,
    input  logic [A_W-1:0] a_in,
    input  logic [B_W_DEF-1:0] b_in,
    output logic [A_W-1:0] a,
    output logic [N-1:0]   b_i,
    output logic [N-1:0]   b_j,
    output logic           one_term,
    output logic           b_sign,
    output logic           vld,
    output logic           pair_neg,
    output logic           term_zero,
    output logic           last,
    input  logic           out_rdy
);

    state_t         state_r, state_s;
    logic [M_W-1:0] pos_r, neg_r;
    logic [M_W-1:0] rec_pos_s, rec_neg_s;
    logic [A_W-1:0] a_r;
    logic           zero_r;
    logic           init_r;

    logic [M_W-1:0] all_s, rem_s, after_s, clear_s;
    msb_t           h_s, l_s;
    logic           issue_s, xfer_s, last_s, load_s, in_rdy_s;

    csd_recode u_recode (
        .b_in     (b_in),
        .pos_mask (rec_pos_s),
        .neg_mask (rec_neg_s)
    );

    // Digit selection: h is the top digit; l is the next digit below h
    always_comb begin
        all_s = pos_r | neg_r;
        h_s   = find_msb(all_s);
        rem_s = all_s & ~(16'd1 << h_s.idx);
        l_s   = find_msb(rem_s);
        if (l_s.found) begin
            after_s = rem_s & ~(16'd1 << l_s.idx);
        end else begin
            after_s = rem_s;
        end
        clear_s = all_s & ~after_s;
    end

    // Handshake decode
    // - in_rdy is held low until the first clock after reset release
    // - in ISSUE, in_rdy opens only while the final beat transfers, so a new
    //   operand follows without a bubble
    always_comb begin
        issue_s = (state_r == ISSUE);
        last_s  = issue_s & (after_s == 16'd0);
        xfer_s  = issue_s & out_rdy;
        if (state_r == IDLE) begin
            in_rdy_s = init_r;
        end else begin
            in_rdy_s = init_r & xfer_s & last_s;
        end
        load_s = in_rdy_s & in_vld;
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_s = ISSUE;
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE: begin
                if (xfer_s && last_s && !load_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and readiness flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            init_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            init_r  <= 1'b1;
        end
    end

    // Operand registers
    // - load on acceptance
    // - on each transfer, retire the issued digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r    <= '0;
            pos_r  <= '0;
            neg_r  <= '0;
            zero_r <= 1'b0;
        end else if (load_s) begin
            a_r    <= a_in;
            pos_r  <= rec_pos_s;
            neg_r  <= rec_neg_s;
            zero_r <= (b_in == 15'd0);
        end else if (xfer_s) begin
            pos_r  <= pos_r & ~clear_s;
            neg_r  <= neg_r & ~clear_s;
        end else begin
            pos_r  <= pos_r;
            neg_r  <= neg_r;
        end
    end

    // Beat outputs, all zero outside ISSUE
    always_comb begin
        in_rdy    = in_rdy_s;
        a         = a_r;
        vld       = 1'b0;
        b_i       = '0;
        b_j       = '0;
        one_term  = 1'b0;
        b_sign    = 1'b0;
        pair_neg  = 1'b0;
        term_zero = 1'b0;
        last      = 1'b0;
        if (issue_s) begin
            vld       = 1'b1;
            b_i       = h_s.idx;
            one_term  = ~l_s.found;
            pair_neg  = h_s.found & neg_r[h_s.idx];
            term_zero = zero_r;
            last      = last_s;
            if (l_s.found) begin
                b_j    = l_s.idx;
                b_sign = neg_r[h_s.idx] ^ neg_r[l_s.idx];
            end else begin
                b_j    = '0;
                b_sign = 1'b0;
            end
        end else begin
            vld = 1'b0;
        end
    end

endmodule

// File: tb/tb_csd_term_issuer.sv
module tb_csd_term_issuer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_vld;
    logic        in_rdy;
    logic [15:0] a_in;
    logic [14:0] b_in;
    logic [15:0] a;
    logic [3:0]  b_i;
    logic [3:0]  b_j;
    logic        one_term;
    logic        b_sign;
    logic        vld;
    logic        pair_neg;
    logic        term_zero;
    logic        last;
    logic        out_rdy;

    int checks   = 0;
    int failures = 0;
    int acc      = 0;

    csd_term_issuer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_vld    (in_vld),
        .in_rdy    (in_rdy),
        .a_in      (a_in),
        .b_in      (b_in),
        .a         (a),
        .b_i       (b_i),
        .b_j       (b_j),
        .one_term  (one_term),
        .b_sign    (b_sign),
        .vld       (vld),
        .pair_neg  (pair_neg),
        .term_zero (term_zero),
        .last      (last),
        .out_rdy   (out_rdy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Check every field of the current beat, fold it into the product model,
    // then advance to the next falling edge.
    task automatic beat(input string tag, input int ebi, input int ebj, input bit esign,
                        input bit eone, input bit eneg, input bit ezero, input bit elast);
        int term;
        chk({tag, ".vld"},       32'(vld),       32'd1);
        chk({tag, ".b_i"},       32'(b_i),       32'(ebi));
        chk({tag, ".b_j"},       32'(b_j),       32'(ebj));
        chk({tag, ".b_sign"},    32'(b_sign),    32'(esign));
        chk({tag, ".one_term"},  32'(one_term),  32'(eone));
        chk({tag, ".pair_neg"},  32'(pair_neg),  32'(eneg));
        chk({tag, ".term_zero"}, 32'(term_zero), 32'(ezero));
        chk({tag, ".last"},      32'(last),      32'(elast));
        term = int'(a) << b_i;
        if (!one_term) begin
            if (b_sign) term = term - (int'(a) << b_j);
            else        term = term + (int'(a) << b_j);
        end
        if (pair_neg)  term = -term;
        if (term_zero) term = 0;
        acc = acc + term;
        @(negedge clk);
    endtask

    task automatic send(input logic [15:0] av, input logic [14:0] bv);
        chk("send.in_rdy", 32'(in_rdy), 32'd1);
        in_vld = 1'b1;
        a_in   = av;
        b_in   = bv;
        acc    = 0;
        @(negedge clk);
        in_vld = 1'b0;
    endtask

    initial begin
        rst_n   = 1'b0;
        in_vld  = 1'b0;
        a_in    = '0;
        b_in    = '0;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("rst.vld",    32'(vld),    32'd0);
        chk("rst.in_rdy", 32'(in_rdy), 32'd0);
        chk("rst.a",      32'(a),      32'd0);
        chk("rst.b_i",    32'(b_i),    32'd0);
        chk("rst.last",   32'(last),   32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle.in_rdy", 32'(in_rdy), 32'd1);

        // 7 = 8 - 1, a=3 -> 21
        send(16'd3, 15'h0007);
        beat("b7", 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b7.product", 32'(acc), 32'd21);
        chk("b7.idle_vld", 32'(vld), 32'd0);
        chk("b7.idle_rdy", 32'(in_rdy), 32'd1);

        // 11 = 16 - 4 - 1, a=5 -> 55
        send(16'd5, 15'h000B);
        beat("b11.1", 4, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b11.2", 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("b11.product", 32'(acc), 32'd55);

        // 0x5555, a=1
        send(16'd1, 15'h5555);
        beat("b5555.1", 14, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b5555.2", 10, 8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b5555.3", 6,  4,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("b5555.4", 2,  0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b5555.product", 32'(acc), 32'h5555);

        // zero operand, then 0x7FFF = 2^15 - 1 with a=2
        send(16'd9, 15'h0000);
        beat("b0", 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("b0.product", 32'(acc), 32'd0);
        send(16'd2, 15'h7FFF);
        beat("b7fff", 15, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b7fff.product", 32'(acc), 32'd65534);

        // stall on beat 2, then back-to-back operand on beat 4
        send(16'h1234, 15'h5555);
        beat("stall.1", 14, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        out_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall.hold_bi", 32'(b_i), 32'd10);
            chk("stall.hold_bj", 32'(b_j), 32'd8);
            chk("stall.hold_vld", 32'(vld), 32'd1);
            chk("stall.hold_a", 32'(a), 32'h1234);
            chk("stall.in_rdy", 32'(in_rdy), 32'd0);
            @(negedge clk);
        end
        out_rdy = 1'b1;
        beat("stall.2", 10, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        beat("stall.3", 6,  4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("b2b.in_rdy", 32'(in_rdy), 32'd1);
        in_vld = 1'b1;
        a_in   = 16'd3;
        b_in   = 15'h0007;
        beat("stall.4", 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        in_vld = 1'b0;
        chk("stall.product", 32'(acc), 32'h1234 * 32'h5555);
        acc = 0;
        chk("b2b.a", 32'(a), 32'd3);
        beat("b2b", 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("b2b.product", 32'(acc), 32'd21);

        // reset during beat 2
        send(16'd9, 15'h5555);
        beat("rstmid.1", 14, 12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rstmid.b2_bi", 32'(b_i), 32'd10);
        rst_n = 1'b0;
        #1;
        chk("rstmid.vld",      32'(vld),      32'd0);
        chk("rstmid.b_i",      32'(b_i),      32'd0);
        chk("rstmid.b_j",      32'(b_j),      32'd0);
        chk("rstmid.one_term", 32'(one_term), 32'd0);
        chk("rstmid.last",     32'(last),     32'd0);
        chk("rstmid.a",        32'(a),        32'd0);
        chk("rstmid.in_rdy",   32'(in_rdy),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rstrel.in_rdy", 32'(in_rdy), 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("rstrel.no_stale", 32'(vld), 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
